// File: rtl/noc_serdes_pkg.sv
// Shared types and constant helpers for the NoC flit serializer/deserializer family.
package noc_serdes_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } asm_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int flit_width(input int tdata_width, input int ser_factor);
    return tdata_width / ser_factor;
  endfunction

  // Counters need at least one bit even when they only ever hold zero.
  function automatic int cnt_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_flit_deserializer_if.sv
// Flit ingress (send/credit) plus AXI-Stream egress bundle of the flit deserializer.
interface axis_flit_deserializer_if
  import noc_serdes_pkg::*;
#(
  parameter int TDATA_WIDTH          = 512,
  parameter int SERIALIZATION_FACTOR = 4,
  parameter int DEST_WIDTH           = 6
);
  localparam int FLIT_WIDTH = flit_width(TDATA_WIDTH, SERIALIZATION_FACTOR);

  logic [FLIT_WIDTH-1:0]  data_in;
  logic [DEST_WIDTH-1:0]  dest_in;
  logic                   is_tail_in;
  logic                   send_in;
  logic                   credit_out;
  logic                   axis_tvalid;
  logic                   axis_tready;
  logic [TDATA_WIDTH-1:0] axis_tdata;
  logic                   axis_tlast;
  logic [DEST_WIDTH-1:0]  axis_tdest;

  modport slave (
    input  data_in, dest_in, is_tail_in, send_in, axis_tready,
    output credit_out, axis_tvalid, axis_tdata, axis_tlast, axis_tdest
  );

  modport master (
    output data_in, dest_in, is_tail_in, send_in, axis_tready,
    input  credit_out, axis_tvalid, axis_tdata, axis_tlast, axis_tdest
  );
endinterface

// File: rtl/axis_flit_deserializer_fifo.sv
// Flit buffer: stores {tail, dest, data}; a push while full is accepted only alongside a pop.
module flit_fifo
  import noc_serdes_pkg::*;
#(
  parameter int DATA_W = 135,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int AW = cnt_width(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_q, rd_q;
  logic              wr_en;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign wr_en   = push_i && (!full_o || pop_i);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/axis_flit_deserializer.sv
// Reassembles credit-flow-controlled NoC flits into AXI-Stream beats.
// Optional DESER_DEST_CHECK_EN adds a sticky dest_err output for mixed-dest beats.
module axis_flit_deserializer
  import noc_serdes_pkg::*;
#(
  parameter int TDATA_WIDTH          = 512,
  parameter int SERIALIZATION_FACTOR = 4,
  parameter int DEST_WIDTH           = 6,
  parameter int FLIT_BUFFER_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  axis_flit_deserializer_if.slave  bus_if,
`ifdef DESER_DEST_CHECK_EN
  output logic                     dest_err,
`endif
  output logic                     overflow
);
  localparam int FW      = flit_width(TDATA_WIDTH, SERIALIZATION_FACTOR);
  localparam int CNT_W   = cnt_width(SERIALIZATION_FACTOR);
  localparam int ENTRY_W = FW + DEST_WIDTH + 1;

  logic [ENTRY_W-1:0]    fifo_rdata;
  logic                  fifo_full, fifo_empty, pop, hs;
  logic [FW-1:0]         f_data;
  logic [DEST_WIDTH-1:0] f_dest;
  logic                  f_tail;

  asm_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, slot;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [DEST_WIDTH-1:0]  tdest_q, tdest_d;
  logic                   credit_q, overflow_q, overflow_d;

  flit_fifo #(.DATA_W(ENTRY_W), .DEPTH(FLIT_BUFFER_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bus_if.send_in),
    .data_i  ({bus_if.is_tail_in, bus_if.dest_in, bus_if.data_in}),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign f_data = fifo_rdata[FW-1:0];
  assign f_dest = fifo_rdata[FW +: DEST_WIDTH];
  assign f_tail = fifo_rdata[ENTRY_W-1];

  assign hs  = (state_q == HOLD) && bus_if.axis_tready;
  assign pop = !fifo_empty && ((state_q == COLLECT) || hs);
  // A pop in the same cycle frees the slot, so a push on a full FIFO is not a drop.
  assign overflow_d = overflow_q | (bus_if.send_in && fifo_full && !pop);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdest_d  = tdest_q;
    slot     = cnt_q;
    if (hs) begin
      state_d  = COLLECT;
      cnt_d    = '0;
      tdata_d  = '0;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      slot     = '0;
    end
    // After a handshake the popped flit starts the next beat in slot 0.
    if (pop) begin
      tdata_d[slot*FW +: FW] = f_data;
      if ((slot == CNT_W'(SERIALIZATION_FACTOR - 1)) || f_tail) begin
        state_d  = HOLD;
        tvalid_d = 1'b1;
        tlast_d  = f_tail;
        tdest_d  = f_dest;
      end else begin
        cnt_d = slot + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdest_q    <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdest_q    <= tdest_d;
      credit_q   <= pop;
      overflow_q <= overflow_d;
    end
  end

`ifdef DESER_DEST_CHECK_EN
  logic [DEST_WIDTH-1:0] dest0_q, dest0_d;
  logic                  dest_err_q, dest_err_d;

  always_comb begin
    dest0_d    = dest0_q;
    dest_err_d = dest_err_q;
    if (pop) begin
      if (slot == '0) dest0_d = f_dest;
      else if (f_dest != dest0_q) dest_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest0_q    <= '0;
      dest_err_q <= 1'b0;
    end else begin
      dest0_q    <= dest0_d;
      dest_err_q <= dest_err_d;
    end
  end

  assign dest_err = dest_err_q;
`endif

  assign bus_if.credit_out  = credit_q;
  assign bus_if.axis_tvalid = tvalid_q;
  assign bus_if.axis_tdata  = tdata_q;
  assign bus_if.axis_tlast  = tlast_q;
  assign bus_if.axis_tdest  = tdest_q;
  assign overflow           = overflow_q;

endmodule

// File: tb/tb_axis_flit_deserializer.sv
// Self-checking bench: credit-respecting upstream, beat grouping reference model, directed corner cases.
module tb_axis_flit_deserializer;
  localparam int TW    = 512;
  localparam int SF    = 4;
  localparam int DW    = 6;
  localparam int DEPTH = 4;
  localparam int FW    = TW / SF;

  typedef struct packed {
    logic [TW-1:0] d;
    logic          l;
    logic [DW-1:0] dst;
  } beat_t;

  typedef struct packed {
    logic [FW-1:0] d;
    logic [DW-1:0] dst;
    logic          t;
  } flit_t;

  logic clk = 1'b0;
  logic rst_n;
  logic overflow;
`ifdef DESER_DEST_CHECK_EN
  logic dest_err;
`endif

  axis_flit_deserializer_if #(.TDATA_WIDTH(TW), .SERIALIZATION_FACTOR(SF), .DEST_WIDTH(DW)) bus ();

  axis_flit_deserializer #(
    .TDATA_WIDTH(TW), .SERIALIZATION_FACTOR(SF), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_if   (bus),
`ifdef DESER_DEST_CHECK_EN
    .dest_err (dest_err),
`endif
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t obs_beats[$];
  beat_t exp_beats[$];
  flit_t exp_flits[$];
  int    credits_total = 0;
  int    obs_rd = 0;
  int    cred_base = 0;
  int    sent = 0;

  // Observer only; the upstream credit count is derived from it by the stimulus.
  always @(negedge clk) begin
    if (!rst_n) begin
      obs_beats.delete();
      credits_total = 0;
    end else begin
      if (bus.axis_tvalid && bus.axis_tready)
        obs_beats.push_back('{d: bus.axis_tdata, l: bus.axis_tlast, dst: bus.axis_tdest});
      if (bus.credit_out) credits_total++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] rnd_flit();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: flits fill slots from the LSB; a beat closes after SF flits or on a tail.
  task automatic build_exp();
    beat_t b;
    int    k;
    exp_beats.delete();
    b = '0;
    k = 0;
    foreach (exp_flits[i]) begin
      b.d[k*FW +: FW] = exp_flits[i].d;
      k++;
      if (k == SF || exp_flits[i].t) begin
        b.l   = exp_flits[i].t;
        b.dst = exp_flits[i].dst;
        exp_beats.push_back(b);
        b = '0;
        k = 0;
      end
    end
  endtask

  task automatic compare_beats(input string tag);
    int g;
    int n;
    build_exp();
    g = 0;
    while ((obs_beats.size() - obs_rd) < exp_beats.size() && g < 3000) begin
      tick();
      g++;
    end
    repeat (6) tick();
    n = obs_beats.size() - obs_rd;
    chk({tag, "_beat_count"}, n, exp_beats.size());
    for (int i = 0; i < exp_beats.size() && i < n; i++) begin
      chk($sformatf("%s_tdata%0d", tag, i), obs_beats[obs_rd+i].d, exp_beats[i].d);
      chk($sformatf("%s_tlast%0d", tag, i), obs_beats[obs_rd+i].l, exp_beats[i].l);
      chk($sformatf("%s_tdest%0d", tag, i), obs_beats[obs_rd+i].dst, exp_beats[i].dst);
    end
    chk({tag, "_credits"}, credits_total - cred_base, exp_flits.size());
    obs_rd    = obs_beats.size();
    cred_base = credits_total;
    exp_flits.delete();
  endtask

  // Upstream sender: only transmits while it holds a credit.
  task automatic send_flit(input logic [FW-1:0] d, input logic [DW-1:0] dst, input logic t);
    int g;
    g = 0;
    while ((DEPTH - sent + credits_total) <= 0 && g < 500) begin
      bus.send_in = 1'b0;
      tick();
      g++;
    end
    chk("credit_wait", g < 500, 1'b1);
    bus.data_in    = d;
    bus.dest_in    = dst;
    bus.is_tail_in = t;
    bus.send_in    = 1'b1;
    sent++;
    exp_flits.push_back('{d: d, dst: dst, t: t});
    tick();
    bus.send_in = 1'b0;
  endtask

  task automatic reset_books();
    sent      = 0;
    obs_rd    = 0;
    cred_base = 0;
    exp_flits.delete();
  endtask

  initial begin
    int   rdone;
    int   len;
    logic [DW-1:0] pd;

    rst_n           = 1'b0;
    bus.data_in     = '0;
    bus.dest_in     = '0;
    bus.is_tail_in  = 1'b0;
    bus.send_in     = 1'b0;
    bus.axis_tready = 1'b0;
    repeat (3) tick();
    chk("rst_tvalid", bus.axis_tvalid, 1'b0);
    chk("rst_tdata", bus.axis_tdata, '0);
    chk("rst_tlast", bus.axis_tlast, 1'b0);
    chk("rst_tdest", bus.axis_tdest, '0);
    chk("rst_credit", bus.credit_out, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    reset_books();
    tick();

    // One full 4-flit packet.
    bus.axis_tready = 1'b1;
    send_flit(128'h11, 6'd7, 1'b0);
    send_flit(128'h22, 6'd7, 1'b0);
    send_flit(128'h33, 6'd7, 1'b0);
    send_flit(128'h44, 6'd7, 1'b1);
    compare_beats("pkt4");

    // Six flits: one full beat then a short tail beat.
    for (int i = 0; i < 6; i++) send_flit(rnd_flit(), 6'd9, i == 5);
    compare_beats("pkt6");

    // Random packet lengths with random sink back-pressure.
    rdone = 0;
    fork
      begin
        for (int p = 0; p < 25; p++) begin
          len = $urandom_range(1, 9);
          pd  = DW'($urandom);
          for (int i = 0; i < len; i++) send_flit(rnd_flit(), pd, i == len - 1);
        end
        rdone = 1;
      end
      begin
        while (rdone == 0) begin
          bus.axis_tready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    bus.axis_tready = 1'b1;
    compare_beats("rand");
    chk("rand_overflow", overflow, 1'b0);

    // Stalled sink: credits run out after one beat plus a full FIFO.
    bus.axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) send_flit(rnd_flit(), 6'd12, i == 7);
    repeat (20) tick();
    chk("stall_no_beats", obs_beats.size() - obs_rd, 0);
    chk("stall_credits", credits_total - cred_base, 4);
    chk("stall_no_credit_left", DEPTH - sent + credits_total, 0);
    chk("stall_overflow", overflow, 1'b0);
    bus.data_in    = 128'hDEAD_BEEF;
    bus.dest_in    = 6'd1;
    bus.is_tail_in = 1'b1;
    bus.send_in    = 1'b1;
    tick();
    bus.send_in = 1'b0;
    tick();
    chk("drop_overflow", overflow, 1'b1);
    repeat (5) tick();
    chk("drop_no_credit", credits_total - cred_base, 4);
    bus.axis_tready = 1'b1;
    compare_beats("stall");
    chk("overflow_sticky", overflow, 1'b1);

    // Asynchronous reset in the middle of a beat.
    send_flit(rnd_flit(), 6'd4, 1'b0);
    send_flit(rnd_flit(), 6'd4, 1'b0);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", bus.axis_tvalid, 1'b0);
    chk("arst_tdata", bus.axis_tdata, '0);
    chk("arst_tlast", bus.axis_tlast, 1'b0);
    chk("arst_tdest", bus.axis_tdest, '0);
    chk("arst_credit", bus.credit_out, 1'b0);
    chk("arst_overflow", overflow, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    reset_books();
    tick();
    for (int i = 0; i < 3; i++) send_flit(rnd_flit(), 6'd3, i == 2);
    compare_beats("after_rst");

`ifdef DESER_DEST_CHECK_EN
    chk("dest_err_clean", dest_err, 1'b0);
    send_flit(rnd_flit(), 6'd3, 1'b0);
    send_flit(rnd_flit(), 6'd3, 1'b0);
    send_flit(rnd_flit(), 6'd5, 1'b0);
    send_flit(rnd_flit(), 6'd3, 1'b1);
    compare_beats("dest_mix");
    chk("dest_err_set", dest_err, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
